// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with valid/ready handshake, one-entry skid
// buffer, synchronous flush to a NOP bubble, and a saturating downstream-stall counter.
module pipe_stage_skid #(
    parameter int unsigned              DATA_W   = 64,
    parameter int unsigned              CTRL_W   = 8,
    parameter logic [CTRL_W-1:0]        NOP_CTRL = '0,
    parameter int unsigned              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Encoding is {out_valid, skid_valid}; 2'b01 is never entered.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b10,
        SKID  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic accept;
    logic transfer;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != SKID);
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign stall_cnt = stall_cnt_q;

    assign accept   = in_valid & in_ready;
    assign transfer = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            // Payload registers keep stale data; only control is forced inert.
            state_d     = EMPTY;
            main_ctrl_d = NOP_CTRL;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = FULL;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                FULL: begin
                    if (accept && transfer) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (accept) begin
                        state_d     = SKID;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (transfer) begin
                        state_d     = EMPTY;
                        main_ctrl_d = NOP_CTRL;
                    end
                end
                SKID: begin
                    if (transfer) begin
                        state_d     = FULL;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_ctrl_d = NOP_CTRL;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_stats) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= NOP_CTRL;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed plus randomized bench for pipe_stage_skid against a queue-based
// two-entry FIFO reference model.
module tb_pipe_stage_skid;

    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 8;
    localparam int unsigned CNW = 4;
    localparam logic [CW-1:0] NOP = 8'hA5;
    localparam int unsigned CNT_SAT = 15;

    logic           clk = 1'b0;
    logic           rst, flush, in_valid, out_ready, clr_stats;
    logic           in_ready, out_valid;
    logic [DW-1:0]  in_data, out_data;
    logic [CW-1:0]  in_ctrl, out_ctrl;
    logic [CNW-1:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [DW-1:0] mq_data[$];
    logic [CW-1:0] mq_ctrl[$];
    logic [DW-1:0] m_last = '0;
    int unsigned   m_cnt  = 0;

    pipe_stage_skid #(
        .DATA_W   (DW),
        .CTRL_W   (CW),
        .NOP_CTRL (NOP),
        .CNT_W    (CNW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .clr_stats (clr_stats),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int unsigned n;
        n = mq_data.size();
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(n > 0));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(n < 2));
        chk({tag, ".out_data"},  64'(out_data),  64'((n > 0) ? mq_data[0] : m_last));
        chk({tag, ".out_ctrl"},  64'(out_ctrl),  64'((n > 0) ? mq_ctrl[0] : NOP));
        chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_cnt));
    endtask

    task automatic step(input string tag, input logic r, input logic f, input logic iv,
                        input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic clr);
        bit acc, xfer, stl;
        rst = r; flush = f; in_valid = iv; in_data = d; in_ctrl = c;
        out_ready = ordy; clr_stats = clr;
        acc  = iv && (mq_data.size() < 2);
        xfer = (mq_data.size() > 0) && ordy;
        stl  = (mq_data.size() > 0) && !ordy;
        @(posedge clk);
        #1;
        if (r) begin
            mq_data.delete(); mq_ctrl.delete();
            m_last = '0; m_cnt = 0;
        end else begin
            if (clr) m_cnt = 0;
            else if (stl && m_cnt < CNT_SAT) m_cnt++;
            if (f) begin
                mq_data.delete(); mq_ctrl.delete();
            end else begin
                if (xfer) begin
                    void'(mq_data.pop_front());
                    void'(mq_ctrl.pop_front());
                end
                if (acc) begin
                    mq_data.push_back(d);
                    mq_ctrl.push_back(c);
                end
            end
            if (mq_data.size() > 0) m_last = mq_data[0];
        end
        check_all(tag);
    endtask

    initial begin
        logic r, f, iv, ordy, clr;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        out_ready = 1'b0; clr_stats = 1'b0;

        // Reset for two cycles with junk offered
        step("reset0", 1, 0, 1, 32'hDEAD, 8'h11, 1, 0);
        step("reset1", 1, 0, 1, 32'hBEEF, 8'h12, 0, 0);
        step("idle",   0, 0, 0, 32'h0, 8'h0, 1, 0);

        // Stream 1..4 at full throughput
        for (int i = 1; i <= 4; i++)
            step("stream", 0, 0, 1, 32'(i), 8'(8'h20 + i), 1, 0);
        step("stream_drain", 0, 0, 0, 32'h0, 8'h0, 1, 0);

        // Skid fill and drain
        step("skid_a",     0, 0, 1, 32'hA, 8'h3A, 0, 0);
        step("skid_b",     0, 0, 1, 32'hB, 8'h3B, 0, 0);
        step("skid_hold",  0, 0, 1, 32'hC, 8'h3C, 0, 0);
        step("skid_out_a", 0, 0, 0, 32'h0, 8'h0, 1, 0);
        step("skid_out_b", 0, 0, 0, 32'h0, 8'h0, 1, 0);
        step("skid_empty", 0, 0, 0, 32'h0, 8'h0, 1, 0);

        // Flush while in SKID, new input offered in the same cycle
        step("fl_a",     0, 0, 1, 32'hA, 8'h4A, 0, 0);
        step("fl_b",     0, 0, 1, 32'hB, 8'h4B, 0, 0);
        step("fl_flush", 0, 1, 1, 32'hC, 8'h4C, 1, 0);
        step("fl_after", 0, 0, 0, 32'h0, 8'h0, 1, 0);
        step("fl_after2", 0, 0, 0, 32'h0, 8'h0, 1, 0);

        // Sustained accept + transfer in FULL
        for (int i = 0; i < 10; i++)
            step("full_bb", 0, 0, 1, 32'h100 + 32'(i), 8'(8'h50 + i), 1, 0);
        step("full_drain", 0, 0, 0, 32'h0, 8'h0, 1, 0);

        // Stall counter saturation, then clear while still stalled
        step("st_load", 0, 0, 1, 32'h77, 8'h61, 0, 1);
        for (int i = 0; i < 20; i++)
            step("st_sat", 0, 0, 0, 32'h0, 8'h0, 0, 0);
        chk("st_saturated", 64'(stall_cnt), 64'(CNT_SAT));
        step("st_clr",   0, 0, 0, 32'h0, 8'h0, 0, 1);
        chk("st_cleared", 64'(stall_cnt), 64'd0);
        step("st_resume", 0, 0, 0, 32'h0, 8'h0, 0, 0);
        step("st_flush", 0, 1, 0, 32'h0, 8'h0, 0, 0);
        step("st_drain", 0, 0, 0, 32'h0, 8'h0, 1, 0);

        // Reset from SKID with input offered
        step("rm_a",   0, 0, 1, 32'hA1, 8'h71, 0, 0);
        step("rm_b",   0, 0, 1, 32'hB1, 8'h72, 0, 0);
        step("rm_rst", 1, 0, 1, 32'hC1, 8'h73, 1, 0);
        step("rm_after", 0, 0, 0, 32'h0, 8'h0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r    = ($urandom_range(0, 149) == 0);
            f    = ($urandom_range(0, 24) == 0);
            clr  = ($urandom_range(0, 39) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            step("rand", r, f, iv, 32'($urandom), 8'($urandom), ordy, clr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
